// File: rtl/port_display_ctrl_pkg.sv
// rtl/port_display_ctrl_pkg.sv - shared constants for the port display controller
package port_display_ctrl_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low a..g patterns (seg[0]=a), listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/port_display_ctrl_hex7seg.sv
// rtl/port_display_ctrl_hex7seg.sv - 4-bit to active-low seven-segment decoder
module port_display_ctrl_hex7seg
    import port_display_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/port_display_ctrl.sv
// rtl/port_display_ctrl.sv - port capture registers, muxed hex display and CPU tick prescaler
module port_display_ctrl #(
    parameter int WORD_SIZE = port_display_ctrl_pkg::WORD_SIZE,
    parameter int NUM_CHAN  = 4,
    parameter int DIGITS    = 4,
    parameter int SCAN_BITS = 16,
    parameter int SLOWDOWN  = 20,
    localparam int CBITS    = $clog2(NUM_CHAN),
    localparam int DBITS    = $clog2(DIGITS)
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic [2:0]           speed,
    output logic                 cpu_tick,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portset,
    input  logic [CBITS-1:0]     sel,
    input  logic                 blank_lz,
    output logic [DIGITS-1:0]    an,
    output logic [6:0]           seg,
    output logic                 dp
);
    import port_display_ctrl_pkg::*;

    logic [SLOWDOWN:0]      r_acc;
    logic                   r_tick;
    logic [SLOWDOWN+1:0]    w_inc;
    logic [SLOWDOWN+1:0]    w_sum;

    logic                   r_set_meta;
    logic                   r_set_sync;
    logic                   r_set_prev;
    logic                   w_wr;
    logic                   w_addr_hit;
    logic [CBITS-1:0]       w_idx;

    logic [WORD_SIZE-1:0]   r_chan [NUM_CHAN];
    logic [NUM_CHAN-1:0]    r_valid;

    logic [SCAN_BITS-1:0]   r_scan;
    logic [DBITS-1:0]       w_digit;
    logic [WORD_SIZE-1:0]   w_cur;
    logic [3:0]             w_nib;
    logic [6:0]             w_seg;
    logic                   w_blank;
    logic [DIGITS-1:0]      w_an_sel;

    logic [DIGITS-1:0]      r_an;
    logic [6:0]             r_seg;
    logic                   r_dp;

    // The carry out of the accumulator MSB is the tick; the sum is one bit wider to expose it.
    assign w_inc = (SLOWDOWN+2)'(1) << {speed, 1'b0};
    assign w_sum = {1'b0, r_acc} + w_inc;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_acc  <= w_sum[SLOWDOWN:0];
            r_tick <= w_sum[SLOWDOWN+1];
        end
    end

    assign cpu_tick = r_tick;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_set_meta <= 1'b0;
            r_set_sync <= 1'b0;
            r_set_prev <= 1'b0;
        end else begin
            r_set_meta <= portset;
            r_set_sync <= r_set_meta;
            r_set_prev <= r_set_sync;
        end
    end

    // Edge detect is left combinational so the register lands on the 3rd edge after the rise.
    assign w_wr       = r_set_sync & ~r_set_prev;
    assign w_addr_hit = (portaddr[WORD_SIZE-1:CBITS] == '0);
    assign w_idx      = portaddr[CBITS-1:0];

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_chan[i] <= '0;
            end
            r_valid <= '0;
        end else if (w_wr && w_addr_hit) begin
            r_chan[w_idx]  <= portval;
            r_valid[w_idx] <= 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign w_digit  = r_scan[SCAN_BITS-1 -: DBITS];
    assign w_cur    = r_chan[sel];
    assign w_nib    = w_cur[{w_digit, 2'b00} +: 4];
    assign w_an_sel = ~(DIGITS'(1) << w_digit);

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    assign w_blank = blank_lz && (w_digit != '0) && ((w_cur >> {w_digit, 2'b00}) == '0);

    port_display_ctrl_hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_blank ? '1 : w_an_sel;
            r_seg <= w_blank ? SEG_OFF : w_seg;
            r_dp  <= ~((w_digit == '0) && !r_valid[sel]);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: doc/port_display_ctrl.md
Name: port_display_ctrl

Overview:
- Multi-channel, port-mapped output peripheral for the FPGA top level. Runs entirely in the mclk domain.
- Captures CPU port writes into NUM_CHAN word registers and drives a multiplexed DIGITS-digit seven-segment display showing a switch-selected channel, with optional leading-zero blanking.
- Also generates the variable-rate CPU clock-enable pulse, so the CPU core no longer needs a derived clock.

Parameters:
- WORD_SIZE, 16, width of port address/value and of each channel register.
- NUM_CHAN, 4, number of capture channels (power of 2, >=2).
- DIGITS, 4, display digits; DIGITS*4 must equal WORD_SIZE.
- SCAN_BITS, 16, refresh counter width; digit period is 2^(SCAN_BITS-log2(DIGITS)) mclk cycles.
- SLOWDOWN, 20, prescaler accumulator MSB index.

Ports:
- mclk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- speed  in  3  prescaler rate select; increment = 1 << (2*speed).
- cpu_tick  out  1  one-mclk-cycle CPU clock-enable pulse.
- portaddr  in  WORD_SIZE  CPU port address.
- portval  in  WORD_SIZE  CPU port write data.
- portset  in  1  CPU write strobe, asynchronous to mclk.
- sel  in  log2(NUM_CHAN)  channel shown on display.
- blank_lz  in  1  1 = blank leading zero digits.
- an  out  DIGITS  digit enables, active low.
- seg  out  7  segments a..g (seg[0]=a), active low.
- dp  out  1  decimal point, active low.

Behaviour:
- Reset (async on reset_n low; release synchronous to mclk):
  - all channel registers 0, all valid bits 0, prescaler 0, scan counter 0.
  - cpu_tick 0, an all 1, seg 7'h7F, dp 1.
- Prescaler:
  - (SLOWDOWN+1)-bit accumulator adds 1<<(2*speed) every cycle.
  - cpu_tick is registered: high for exactly one cycle following any cycle whose add carries out of bit SLOWDOWN. Never high two consecutive cycles unless speed forces increment >= 2^(SLOWDOWN+1); that case is illegal and is not checked.
  - A speed change takes effect on the next add, with no accumulator reset.
- Write capture:
  - portset passes through a 2-flop synchronizer, then rising-edge detect (one-cycle wr pulse).
  - On wr, if portaddr[WORD_SIZE-1:log2(NUM_CHAN)] == 0, chan[portaddr[log2(NUM_CHAN)-1:0]] <= portval and its valid bit is set. Otherwise the write is ignored.
  - portaddr and portval must be stable from the portset rise until 3 mclk later.
  - Register updated on the 3rd mclk edge after the portset rise.
  - Level-high portset held indefinitely produces a single write.
- Display scan:
  - SCAN_BITS free-running counter; top log2(DIGITS) bits give the digit index d.
  - d=0 is the rightmost digit, showing nibble chan[sel][3:0]; digit d shows nibble d.
  - an, seg and dp are registered, so outputs lag the counter/selected data by 1 cycle.
  - Changing sel or writing the displayed channel appears on outputs 1 cycle after the register/sel change.
- Hex decode: 0-9, A, b, C, d, E, F, standard active-low patterns.
- Leading-zero blanking:
  - When blank_lz=1, digit d is blanked (an[d]=1, seg=7'h7F) if all nibbles >= d are zero.
  - Digit 0 is never blanked, so value 0 shows "0".
- dp is low only while d=0 and valid[sel]=0, i.e. it flags a never-written channel. Otherwise dp=1.
- Only one an bit is low at a time; all an bits are high in reset.

Decomposition:
- Shared package/include: WORD_SIZE, the 16-entry hex-to-segment constant table, and the all-off segment constant.
- One natural sub-module: hex7seg, a combinational 4-bit to 7-bit active-low decoder instantiated once on the muxed nibble.
- Synchronizer, prescaler and scan counter stay inline.

Test Plan:
- Reset: hold reset_n=0 mid-scan -> an=4'hF, seg=7'h7F, dp=1, cpu_tick=0 immediately (async). After release, channel 0 reads 0 with dp low on digit 0.
- Write path: portaddr=1, portval=16'hBEEF, portset pulse, sel=1 -> chan[1]=BEEF at the 3rd mclk edge. Digits 3..0 show B,E,E,F (seg 7'h03, 7'h06, 7'h06, 7'h0E), and dp stays 1 on digit 0.
- Address filter / held strobe: portaddr=16'h0005 write -> no channel changes. portset held high for 100 cycles with portaddr=2 -> exactly one write to chan[2].
- Blanking: chan[0]=16'h0042, blank_lz=1 -> an[3] and an[2] never low; digits show 4, 2. chan[0]=0 -> only digit 0 lit with "0" (7'h40).
- Prescaler: SLOWDOWN=4, speed=0 -> cpu_tick every 32 cycles; speed=1 -> every 8; speed=2 -> every 2; each pulse exactly 1 cycle wide.
- Scan order: SCAN_BITS=4 -> an cycles 1110, 1101, 1011, 0111, each for 4 cycles, never two bits low simultaneously.
